// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline definitions: widths, ALU op codes and forward-select codes.
// Forwarding muxes in execute_cycle are enabled by the EXECUTE_FWD_EN macro.
package riscv_pkg;

   localparam int unsigned DEF_XLEN = 32;
   localparam int unsigned DEF_RA_W = 5;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef enum logic [1:0] {
      FWD_RF  = 2'b00,
      FWD_WB  = 2'b01,
      FWD_MEM = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/alu_unit.sv
// Combinational RV32I ALU with zero flag; reusable outside the execute stage.
module alu_unit
   import riscv_pkg::*;
#(
   parameter int unsigned W = DEF_XLEN
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic [2:0]   alucontrol,
   output logic [W-1:0] result,
   output logic         zero
);

   logic lt;

   assign lt = $signed(a) < $signed(b);

   always_comb begin
      result = '0;
      case (alucontrol)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(W-1){1'b0}}, lt};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, beq resolution and the EX/MEM register.
// Optional macro EXECUTE_FWD_EN enables the forwarding muxes; otherwise operands come from rd1_e/rd2_e.
module execute_cycle
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = DEF_XLEN,
   parameter int unsigned RA_W = DEF_RA_W
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            valid_e,
   input  logic            regwrite_e,
   input  logic            alusrc_e,
   input  logic            memwrite_e,
   input  logic            resultsrc_e,
   input  logic            branch_e,
   input  logic [2:0]      alucontrol_e,
   input  logic [XLEN-1:0] rd1_e,
   input  logic [XLEN-1:0] rd2_e,
   input  logic [XLEN-1:0] imm_ext_e,
   input  logic [XLEN-1:0] pc_e,
   input  logic [XLEN-1:0] pcplus4_e,
   input  logic [RA_W-1:0] rd_e,
   input  logic [1:0]      fwd_a_e,
   input  logic [1:0]      fwd_b_e,
   input  logic [XLEN-1:0] result_w,
   input  logic            hold_m,
   output logic            pcsrc_e,
   output logic [XLEN-1:0] pctarget_e,
   output logic            valid_m,
   output logic            regwrite_m,
   output logic            memwrite_m,
   output logic            resultsrc_m,
   output logic [XLEN-1:0] aluresult_m,
   output logic [XLEN-1:0] writedata_m,
   output logic [XLEN-1:0] pcplus4_m,
   output logic [RA_W-1:0] rd_m
);

   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b_fwd;
   logic [XLEN-1:0] src_b;
   logic [XLEN-1:0] alu_result;
   logic            alu_zero;

   logic            valid_n;
   logic            regwrite_n;
   logic            memwrite_n;
   logic            resultsrc_n;
   logic [XLEN-1:0] aluresult_n;
   logic [XLEN-1:0] writedata_n;
   logic [XLEN-1:0] pcplus4_n;
   logic [RA_W-1:0] rd_n;

`ifdef EXECUTE_FWD_EN
   // Unlisted select code 11 falls back to the register file value.
   always_comb begin
      src_a = rd1_e;
      case (fwd_a_e)
         FWD_WB:  src_a = result_w;
         FWD_MEM: src_a = aluresult_m;
         default: src_a = rd1_e;
      endcase
   end

   always_comb begin
      src_b_fwd = rd2_e;
      case (fwd_b_e)
         FWD_WB:  src_b_fwd = result_w;
         FWD_MEM: src_b_fwd = aluresult_m;
         default: src_b_fwd = rd2_e;
      endcase
   end
`else
   logic unused_fwd;

   assign src_a      = rd1_e;
   assign src_b_fwd  = rd2_e;
   assign unused_fwd = ^{fwd_a_e, fwd_b_e, result_w};
`endif

   assign src_b = alusrc_e ? imm_ext_e : src_b_fwd;

   alu_unit #(.W(XLEN)) u_alu (
      .a          (src_a),
      .b          (src_b),
      .alucontrol (alucontrol_e),
      .result     (alu_result),
      .zero       (alu_zero)
   );

   assign pcsrc_e    = valid_e & branch_e & alu_zero;
   assign pctarget_e = pc_e + imm_ext_e;

   // Bubbles load all-zero so no stale data travels with an invalid slot.
   always_comb begin
      valid_n     = 1'b0;
      regwrite_n  = 1'b0;
      memwrite_n  = 1'b0;
      resultsrc_n = 1'b0;
      aluresult_n = '0;
      writedata_n = '0;
      pcplus4_n   = '0;
      rd_n        = '0;
      if (valid_e) begin
         valid_n     = 1'b1;
         regwrite_n  = regwrite_e;
         memwrite_n  = memwrite_e;
         resultsrc_n = resultsrc_e;
         aluresult_n = alu_result;
         writedata_n = src_b_fwd;
         pcplus4_n   = pcplus4_e;
         rd_n        = rd_e;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_m     <= 1'b0;
         regwrite_m  <= 1'b0;
         memwrite_m  <= 1'b0;
         resultsrc_m <= 1'b0;
         aluresult_m <= '0;
         writedata_m <= '0;
         pcplus4_m   <= '0;
         rd_m        <= '0;
      end else if (!hold_m) begin
         valid_m     <= valid_n;
         regwrite_m  <= regwrite_n;
         memwrite_m  <= memwrite_n;
         resultsrc_m <= resultsrc_n;
         aluresult_m <= aluresult_n;
         writedata_m <= writedata_n;
         pcplus4_m   <= pcplus4_n;
         rd_m        <= rd_n;
      end
   end

endmodule

// File: doc/execute_cycle.md
Name: execute_cycle

Overview:
- Execute stage of the 5-stage RV32I pipeline.
- Consumes the ID/EX register outputs of the decode stage: control bits, operands, immediate, PC and destination register.
- Performs the ALU operation, computes the branch target, resolves beq, and drives the EX/MEM pipeline register into the memory stage.
- Also returns the branch redirect (pcsrc/pctarget) to fetch.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_e  in  1  ID/EX slot holds a real instruction.
- regwrite_e  in  1  instruction writes rd.
- alusrc_e  in  1  0 = operand B from rs2, 1 = from imm_ext_e.
- memwrite_e  in  1  store.
- resultsrc_e  in  1  0 = ALU result, 1 = load data at writeback.
- branch_e  in  1  beq.
- alucontrol_e  in  3  ALU op select.
- rd1_e, rd2_e  in  XLEN  register operands.
- imm_ext_e  in  XLEN  sign-extended immediate.
- pc_e, pcplus4_e  in  XLEN  instruction PC and PC+4.
- rd_e  in  RA_W  destination register.
- fwd_a_e, fwd_b_e  in  2  forward selects: 00 = regfile, 01 = result_w, 10 = aluresult_m.
- result_w  in  XLEN  writeback result.
- hold_m  in  1  memory stage stalled; EX/MEM holds.
- pcsrc_e  out  1  redirect fetch (combinational).
- pctarget_e  out  XLEN  branch target pc_e + imm_ext_e (combinational).
- valid_m, regwrite_m, memwrite_m, resultsrc_m  out  1  registered control.
- aluresult_m, writedata_m, pcplus4_m  out  XLEN  registered data.
- rd_m  out  RA_W  registered destination.

Behaviour:
- Reset: while rst is low, every registered output is 0, asynchronously.
  - Reset asserted mid-stream discards the in-flight instruction; no partial state survives.
- Operand A = fwd_a_e mux (rd1_e / result_w / aluresult_m).
  - Encoding 11 selects rd1_e.
- Forwarded B = the same mux on rd2_e (select fwd_b_e). It feeds writedata.
- Operand B = alusrc_e ? imm_ext_e : forwarded B.
- ALU, XLEN bits, results truncated modulo 2^XLEN:
  - 000 add, 001 sub, 010 and, 011 or.
  - 101 slt: signed, result 1 or 0, zero-extended.
  - Other codes: result 0.
- zero = (ALU result == 0).
- pcsrc_e = valid_e & branch_e & zero, combinational.
  - pctarget_e is always driven, independent of valid_e.
- EX/MEM register, one-cycle latency:
  - At a rising clk edge with hold_m = 0, load valid, control, aluresult, writedata, pcplus4 and rd from the current execute values.
  - If valid_e = 0, load a bubble: valid_m, regwrite_m, memwrite_m and resultsrc_m = 0. Data fields are don't-care and are loaded as 0.
  - With hold_m = 1, all EX/MEM outputs hold their value. The current execute inputs are not captured; upstream is responsible for holding ID/EX.
  - hold_m and valid_e = 0 together: hold wins.
- No FSM beyond the pipeline register; no internal state other than EX/MEM.

Optional Feature:
- Macro: EXECUTE_FWD_EN.
- Defined: forwarding muxes behave as described above.
- Undefined: fwd_a_e, fwd_b_e, result_w and aluresult_m are ignored, and operands come directly from rd1_e and rd2_e. The pipeline then relies on stall-only hazard handling.
- Port list is identical in both builds.

Decomposition:
- Shared package riscv_pkg:
  - ALU op codes (ALU_ADD = 3'b000, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT).
  - Forward-select codes (FWD_RF, FWD_WB, FWD_MEM).
  - XLEN default.
- Sub-module alu_unit: combinational; inputs a, b, alucontrol; outputs result, zero. It is reusable by later stages and testable alone.
- The pipeline register stays in execute_cycle.

Test Plan:
- Reset: assert rst=0 mid-run with valid_m=1 → all registered outputs are 0 immediately, before any clock edge; after release with valid_e=0, outputs stay 0.
- add/sub: rd1_e=7, rd2_e=5, alusrc_e=0.
  - alucontrol=000 → next edge aluresult_m=12.
  - alucontrol=001 → aluresult_m=2.
  - rd1_e=0, rd2_e=1, sub → aluresult_m=32'hFFFFFFFF.
- slt signed: rd1_e=32'hFFFFFFFF, imm_ext_e=1, alusrc_e=1, alucontrol=101 → aluresult_m=1; swap operands → 0.
- Branch: branch_e=1, valid_e=1, rd1_e=rd2_e=9, alucontrol=001, pc_e=0x100, imm_ext_e=0x20 → pcsrc_e=1, pctarget_e=0x120.
  - Same stimulus with valid_e=0 → pcsrc_e=0.
  - Same stimulus with rd2_e=8 → pcsrc_e=0.
- Forwarding (EXECUTE_FWD_EN defined): fwd_a_e=10, aluresult_m=40, rd1_e=1, rd2_e=2, add → aluresult_m=42 on the next edge.
  - fwd_b_e=01, result_w=3, memwrite_e=1 → writedata_m=3.
- Hold/bubble:
  - hold_m=1 for 3 cycles while the inputs change → outputs are unchanged.
  - Release with valid_e=0 → regwrite_m=memwrite_m=valid_m=0 next edge.
